// File: rtl/pid_pkg.sv
// Shared types and arithmetic helpers for the zoned PID controller.
package pid_pkg;

  typedef enum logic [2:0] {IDLE, ERR, SEL, MUL, SUM} pid_state_e;

  localparam logic [31:0] MIN_PERIOD = 32'd5;

  // Wide enough for every intermediate (2*DW+2 bits) while DW stays <= 62.
  localparam int WIDE = 128;
  typedef logic signed [WIDE-1:0] wide_t;

  function automatic wide_t sat_to(input wide_t x, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic wide_t clamp_sym(input wide_t x, input wide_t lim);
    if (x > lim) return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

endpackage

// File: rtl/zoned_pid_ctl_if.sv
// Register-file and actuator-side signals of the zoned PID controller.
interface zoned_pid_ctl_if #(
    parameter int DW = 32,
    parameter int NZ = 3
);
    import pid_pkg::*;

    localparam int ZW = $clog2(NZ + 1);

    logic                   enable;
    logic [31:0]            period;
    logic signed [DW-1:0]   aim;
    logic signed [DW-1:0]   cur;
    logic [NZ*DW-1:0]       thr;
    logic [NZ*DW-1:0]       kp;
    logic [NZ*DW-1:0]       ki;
    logic [NZ*DW-1:0]       kd;
    logic [DW-1:0]          i_lim;
    logic [DW-1:0]          out_lim;
    logic                   integ_clr;
    // out_valid is a one-cycle strobe with no ready: pid_out/sat/zone are stable
    // from that cycle until the next strobe, and the consumer must not stall it.
    logic signed [DW-1:0]   pid_out;
    logic                   out_valid;
    logic                   sat;
    logic [ZW-1:0]          zone;
    pid_state_e             dbg_state;

    modport master (
        output enable, period, aim, cur, thr, kp, ki, kd, i_lim, out_lim, integ_clr,
        input  pid_out, out_valid, sat, zone, dbg_state
    );

    modport slave (
        input  enable, period, aim, cur, thr, kp, ki, kd, i_lim, out_lim, integ_clr,
        output pid_out, out_valid, sat, zone, dbg_state
    );

endinterface

// File: rtl/pid_zone_sel.sv
// Picks the highest zone whose threshold |err| exceeds and returns its gains.
module pid_zone_sel #(
    parameter int DW = 32,
    parameter int NZ = 3,
    parameter int ZW = $clog2(NZ + 1)
) (
    input  logic signed [DW-1:0] err,
    input  logic [NZ*DW-1:0]     thr,
    input  logic [NZ*DW-1:0]     kp,
    input  logic [NZ*DW-1:0]     ki,
    input  logic [NZ*DW-1:0]     kd,
    output logic [ZW-1:0]        zone,
    output logic signed [DW-1:0] kp_sel,
    output logic signed [DW-1:0] ki_sel,
    output logic signed [DW-1:0] kd_sel
);

    logic [DW:0] abs_err;

    always_comb begin
        abs_err = err[DW-1] ? -{err[DW-1], err} : {err[DW-1], err};
        zone    = '0;
        kp_sel  = '0;
        ki_sel  = '0;
        kd_sel  = '0;
        // Later zones override earlier ones, so the highest match wins.
        for (int i = 0; i < NZ; i++) begin
            if (abs_err > {1'b0, thr[i*DW +: DW]}) begin
                zone   = ZW'(i + 1);
                kp_sel = kp[i*DW +: DW];
                ki_sel = ki[i*DW +: DW];
                kd_sel = kd[i*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/zoned_pid_ctl.sv
// Zoned PID controller: periodic tick, four-stage calculation, clamped output.
module zoned_pid_ctl
    import pid_pkg::*;
#(
    parameter int DW    = 32,
    parameter int NZ    = 3,
    parameter int SHIFT = 0
) (
    input  logic           CLK,
    input  logic           RST_n,
    zoned_pid_ctl_if.slave bus
);

    localparam int ZW = $clog2(NZ + 1);

    pid_state_e             state_q, state_d;
    logic [31:0]            cnt_q, per_q, per_eff;
    logic                   tick;
    logic signed [DW-1:0]   err_n, diff_n, integ_n;
    logic signed [DW-1:0]   err_q, diff_q, err_prev_q, integ_q;
    logic [NZ*DW-1:0]       thr_q, kp_q, ki_q, kd_q;
    logic [DW-1:0]          ilim_q, olim_q;
    logic [ZW-1:0]          zsel, zone_q;
    logic signed [DW-1:0]   kp_sel, ki_sel, kd_sel, kp_r, ki_r, kd_r;
    logic signed [2*DW-1:0] prod_p, prod_i, prod_d;
    wide_t                  sum_w, out_w;
    logic                   sat_n, hold_integ;

    assign per_eff = (bus.period < MIN_PERIOD) ? MIN_PERIOD : bus.period;
    assign tick    = bus.enable && (cnt_q == '0) && (state_q == IDLE);

    pid_zone_sel #(.DW(DW), .NZ(NZ), .ZW(ZW)) u_zone_sel (
        .err    (err_q),
        .thr    (thr_q),
        .kp     (kp_q),
        .ki     (ki_q),
        .kd     (kd_q),
        .zone   (zsel),
        .kp_sel (kp_sel),
        .ki_sel (ki_sel),
        .kd_sel (kd_sel)
    );

    // Each state names the stage whose results sit in registers during it;
    // the tick edge itself performs the ERR snapshot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick) state_d = ERR;
            ERR:     state_d = SEL;
            SEL:     state_d = MUL;
            MUL:     state_d = SUM;
            SUM:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.out_valid = (state_q == SUM);
    assign bus.dbg_state = state_q;

    always_comb begin
        err_n  = DW'(sat_to(wide_t'(bus.cur) - wide_t'(bus.aim), DW));
        diff_n = DW'(sat_to(wide_t'(err_n) - wide_t'(err_prev_q), DW));
        sum_w  = (wide_t'(prod_p) + wide_t'(prod_i) + wide_t'(prod_d)) >>> SHIFT;
        out_w  = clamp_sym(sum_w, wide_t'(olim_q & {1'b0, {(DW-1){1'b1}}}));
        sat_n  = (out_w != sum_w);
        // Anti-windup: freeze the integrator when clamped and err pushes further out.
        hold_integ = (zone_q == '0) ||
                     (sat_n && (err_q != '0) && (sum_w != '0) && (err_q[DW-1] == sum_w[WIDE-1]));
        integ_n = DW'(sat_to(clamp_sym(wide_t'(integ_q) + wide_t'(err_q), wide_t'(ilim_q)), DW));
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt_q <= '0;
            per_q <= MIN_PERIOD;
        end else if (!bus.enable) begin
            cnt_q <= '0;
        end else if (cnt_q == '0) begin
            per_q <= per_eff;
            cnt_q <= 32'd1;
        end else if (cnt_q >= per_q - 32'd1) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= IDLE;
            err_q       <= '0;
            diff_q      <= '0;
            err_prev_q  <= '0;
            integ_q     <= '0;
            thr_q       <= '0;
            kp_q        <= '0;
            ki_q        <= '0;
            kd_q        <= '0;
            ilim_q      <= '0;
            olim_q      <= '0;
            zone_q      <= '0;
            kp_r        <= '0;
            ki_r        <= '0;
            kd_r        <= '0;
            prod_p      <= '0;
            prod_i      <= '0;
            prod_d      <= '0;
            bus.pid_out <= '0;
            bus.sat     <= 1'b0;
            bus.zone    <= '0;
        end else begin
            state_q <= state_d;
            if (tick) begin
                err_q      <= err_n;
                diff_q     <= diff_n;
                err_prev_q <= err_n;
                thr_q      <= bus.thr;
                kp_q       <= bus.kp;
                ki_q       <= bus.ki;
                kd_q       <= bus.kd;
                ilim_q     <= bus.i_lim;
                olim_q     <= bus.out_lim;
            end
            if (state_q == ERR) begin
                zone_q <= zsel;
                kp_r   <= kp_sel;
                ki_r   <= ki_sel;
                kd_r   <= kd_sel;
            end
            if (state_q == SEL) begin
                prod_p <= (2*DW)'(kp_r) * (2*DW)'(err_q);
                prod_i <= (2*DW)'(ki_r) * (2*DW)'(integ_q);
                prod_d <= (2*DW)'(kd_r) * (2*DW)'(diff_q);
            end
            if (state_q == MUL) begin
                bus.pid_out <= DW'(out_w);
                bus.sat     <= sat_n;
                bus.zone    <= zone_q;
            end
            if (bus.integ_clr) begin
                integ_q <= '0;
            end else if ((state_q == MUL) && !hold_integ) begin
                integ_q <= integ_n;
            end
        end
    end

endmodule

// File: tb/tb_zoned_pid_ctl.sv
// Scoreboard bench for zoned_pid_ctl: tick-level reference model vs. DUT outputs.
module tb_zoned_pid_ctl;
  import pid_pkg::*;

  localparam int DW    = 32;
  localparam int NZ    = 3;
  localparam int SHIFT = 0;
  localparam int EW    = 32 + 8 + 1 + DW;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;

  zoned_pid_ctl_if #(.DW(DW), .NZ(NZ)) bus ();

  zoned_pid_ctl #(.DW(DW), .NZ(NZ), .SHIFT(SHIFT)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int edge_n   = 0;
  logic [EW-1:0] exp_q[$];

  longint thr_a[NZ];
  longint kp_a[NZ];
  longint ki_a[NZ];
  longint kd_a[NZ];
  longint ol_v;
  longint il_v;

  longint m_integ;
  longint m_eprev;
  longint m_pos;
  longint m_per;

  task automatic check(string name, logic signed [63:0] act, logic signed [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic longint sat32(longint x);
    if (x > MAXV) return MAXV;
    if (x < MINV) return MINV;
    return x;
  endfunction

  function automatic longint clampl(longint x, longint lim);
    if (x > lim) return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < NZ; i++) begin
      bus.thr[i*DW +: DW] = 32'(thr_a[i]);
      bus.kp[i*DW +: DW]  = 32'(kp_a[i]);
      bus.ki[i*DW +: DW]  = 32'(ki_a[i]);
      bus.kd[i*DW +: DW]  = 32'(kd_a[i]);
    end
    bus.out_lim = 32'(ol_v);
    bus.i_lim   = 32'(il_v);
  endtask

  task automatic set_io(longint a, longint c);
    bus.aim = 32'(a);
    bus.cur = 32'(c);
  endtask

  task automatic set_gains(longint p0, longint p1, longint p2, longint i_all, longint d2);
    kp_a[0] = p0; kp_a[1] = p1; kp_a[2] = p2;
    for (int i = 0; i < NZ; i++) begin
      ki_a[i] = i_all;
      kd_a[i] = 0;
    end
    kd_a[2] = d2;
    apply_cfg();
  endtask

  // ---------------- reference model ----------------
  // One whole calculation per tick, straight from the control law.
  task automatic model_tick();
    longint err, diff, ae, s, cl, ol, gp, gi, gd;
    int z;
    bit st;
    err = sat32(longint'($signed(bus.cur)) - longint'($signed(bus.aim)));
    diff = sat32(err - m_eprev);
    m_eprev = err;
    ae = (err < 0) ? -err : err;
    z = 0;
    for (int i = 0; i < NZ; i++) if (ae > thr_a[i]) z = i + 1;
    gp = 0; gi = 0; gd = 0;
    if (z > 0) begin
      gp = kp_a[z-1]; gi = ki_a[z-1]; gd = kd_a[z-1];
    end
    s = (gp * err + gd * diff + gi * m_integ) >>> SHIFT;
    ol = ol_v & 64'h7FFF_FFFF;
    cl = clampl(s, ol);
    st = (cl != s);
    if (z != 0 && !(st && err != 0 && s != 0 && ((err > 0) == (s > 0))))
      m_integ = sat32(clampl(m_integ + err, il_v));
    exp_q.push_back({32'(edge_n + 3), 8'(z), st, 32'(cl)});
  endtask

  initial begin
    m_integ = 0; m_eprev = 0; m_pos = 0; m_per = 5;
    forever begin
      @(posedge CLK);
      edge_n++;
      if (!RST_n) begin
        m_integ = 0; m_eprev = 0; m_pos = 0; m_per = 5;
        exp_q.delete();
      end else begin
        if (bus.enable && m_pos == 0) model_tick();
        if (!bus.enable) m_pos = 0;
        else begin
          if (m_pos == 0) m_per = (bus.period < 5) ? 5 : longint'(bus.period);
          m_pos = (m_pos + 1) % m_per;
        end
        if (bus.integ_clr) m_integ = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] e;
    logic [31:0] due;
    forever begin
      @(negedge CLK);
      if (RST_n) begin
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_valid: out_valid=1 at edge %0d, expected 0", edge_n);
          end else begin
            e = exp_q.pop_front();
            check("latency", edge_n, e[EW-1:DW+9]);
            check("pid_out", $signed(bus.pid_out), $signed(e[DW-1:0]));
            check("sat", bus.sat, e[DW]);
            check("zone", bus.zone, e[DW+8:DW+1]);
          end
        end else if (exp_q.size() > 0) begin
          e = exp_q[0];
          due = e[EW-1:DW+9];
          if (due < 32'(edge_n)) begin
            n_checks++;
            $display("FAIL missing_valid: out_valid=0 at edge %0d, expected 1 at edge %0d", edge_n, due);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    longint a, c;
    bus.enable = 1'b0;
    bus.period = 32'd10;
    bus.integ_clr = 1'b0;
    set_io(0, 0);
    thr_a[0] = 10; thr_a[1] = 40; thr_a[2] = 100;
    ol_v = 1000; il_v = 1000;
    set_gains(1, 2, 3, 0, 0);

    wait_cycles(3);
    check("rst_pid_out", bus.pid_out, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sat", bus.sat, 0);
    check("rst_zone", bus.zone, 0);
    RST_n = 1'b1;
    wait_cycles(2);

    // zero error, regular ticks
    bus.enable = 1'b1;
    wait_cycles(30);
    // zone 2 proportional
    set_io(100, 150);
    wait_cycles(20);
    // deadband with integrator enabled
    set_gains(1, 2, 3, 1, 0);
    set_io(100, 105);
    wait_cycles(30);
    set_io(100, 150);
    wait_cycles(20);
    // derivative
    set_gains(1, 2, 3, 0, 1);
    wait_cycles(10);
    set_io(100, 250);
    wait_cycles(20);
    // saturation and anti-windup
    ol_v = 200;
    set_gains(1, 2, 3, 1, 0);
    wait_cycles(40);
    set_io(100, -50);
    wait_cycles(30);
    // integrator clear while idle
    bus.enable = 1'b0;
    wait_cycles(10);
    bus.integ_clr = 1'b1;
    wait_cycles(1);
    bus.integ_clr = 1'b0;
    bus.enable = 1'b1;
    wait_cycles(20);
    // boundaries: zero output limit, ignored MSB, saturated error, short period
    ol_v = 0; apply_cfg();
    set_io(100, 150);
    wait_cycles(20);
    ol_v = 64'h8000_0064; apply_cfg();
    wait_cycles(20);
    ol_v = 64'h7FFF_FFFF; set_gains(1, 1, 1, 0, 1);
    set_io(MINV, MAXV);
    wait_cycles(20);
    set_io(MAXV, MINV);
    wait_cycles(10);
    bus.period = 32'd3;
    set_io(0, 70);
    wait_cycles(20);
    bus.period = 32'd7;
    wait_cycles(21);

    // randomized configurations and errors
    for (int it = 0; it < 25; it++) begin
      thr_a[0] = longint'($urandom_range(0, 100));
      thr_a[1] = thr_a[0] + longint'($urandom_range(0, 200));
      thr_a[2] = thr_a[1] + longint'($urandom_range(0, 200));
      for (int i = 0; i < NZ; i++) begin
        kp_a[i] = longint'($urandom_range(0, 8)) - 4;
        ki_a[i] = longint'($urandom_range(0, 4)) - 2;
        kd_a[i] = longint'($urandom_range(0, 4)) - 2;
      end
      ol_v = longint'($urandom_range(0, 3000));
      il_v = longint'($urandom_range(0, 2000));
      apply_cfg();
      a = longint'($urandom_range(0, 1200)) - 600;
      c = longint'($urandom_range(0, 1200)) - 600;
      set_io(a, c);
      bus.period = 32'($urandom_range(0, 12));
      wait_cycles(int'($urandom_range(5, 25)));
    end

    // reset while the calculation sits in MUL
    bus.period = 32'd10;
    thr_a[0] = 10; thr_a[1] = 40; thr_a[2] = 100;
    ol_v = 1000; il_v = 1000;
    set_gains(1, 2, 3, 0, 0);
    set_io(100, 150);
    wait_cycles(25);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge CLK);
      if (bus.dbg_state == MUL) found = 1'b1;
    end
    check("reach_mul", found, 1);
    RST_n = 1'b0;
    #1;
    check("mid_rst_pid_out", bus.pid_out, 0);
    check("mid_rst_sat", bus.sat, 0);
    check("mid_rst_valid", bus.out_valid, 0);
    wait_cycles(2);
    RST_n = 1'b1;
    wait_cycles(30);

    bus.enable = 1'b0;
    wait_cycles(15);
    check("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
